reaction_ctrl: RTL

Control FSM for the reaction-timer game. It drives the 2-bit `state` code consumed by the reaction datapath and consumes that datapath's `FLAG` (end of random delay). It also conditions the player's push-button and generates the slow datapath clock (one datapath count per tick, 100 Hz by default). It sits between the board key/clock pins and the datapath.

---
 rtl/reaction_ctrl.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/reaction_ctrl.sv
// reaction_ctrl: control FSM for the reaction-timer game.
//
// Generates the slow datapath clock. Conditions the player's push-button into a
// single-cycle press pulse. Sequences IDLE -> DELAY -> TIMING -> DISPLAY and
// flags false starts and timeouts.
//
// Ports:
//   Clock      in   system clock, rising edge
//   Resetn     in   asynchronous active-low reset
//   KEYn       in   raw push-button, active-low, asynchronous to Clock
//   FLAG       in   delay-expired level from the datapath (SlowClock domain)
//   state      out  registered FSM code: 0 IDLE, 1 DELAY, 2 TIMING, 3 DISPLAY
//   SlowClock  out  50% duty clock at TICK_HZ for the datapath
//   Early      out  false-start indicator
//   Timeout    out  reaction exceeded MAX_TICKS slow ticks
module reaction_ctrl #(
    parameter int CLK_HZ    = 50000000,
    parameter int TICK_HZ   = 100,
    parameter int DB_CYCLES = 1000000,
    parameter int MAX_TICKS = 100
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       KEYn,
    input  logic       FLAG,
    output logic [1:0] state,
    output logic       SlowClock,
    output logic       Early,
    output logic       Timeout
);

    localparam int DIV   = CLK_HZ / (2 * TICK_HZ);
    localparam int DIV_W = $clog2(DIV + 1);
    localparam int DB_W  = $clog2(DB_CYCLES + 1);
    localparam int DW_MX = (MAX_TICKS > 2) ? MAX_TICKS : 2;
    localparam int DW_W  = $clog2(DW_MX + 1);

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_DELAY   = 2'd1;
    localparam logic [1:0] S_TIMING  = 2'd2;
    localparam logic [1:0] S_DISPLAY = 2'd3;

    // ---------------- slow clock divider ----------------
    logic [DIV_W-1:0] div_cnt;
    logic             div_wrap;
    logic             tick;

    assign div_wrap = (div_cnt == DIV_W'(DIV - 1));
    // The tick is high in the cycle whose closing edge drives SlowClock 0->1.
    assign tick     = div_wrap && !SlowClock;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            div_cnt   <= '0;
            SlowClock <= 1'b0;
        end else if (div_wrap) begin
            div_cnt   <= '0;
            SlowClock <= ~SlowClock;
        end else begin
            div_cnt   <= div_cnt + 1'b1;
        end
    end

    // ---------------- key synchronizer, debounce, edge detect ----------------
    logic            key_m, key_s;
    logic            key_db, key_db_d;
    logic [DB_W-1:0] db_cnt;
    logic            press;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            key_m    <= 1'b1;
            key_s    <= 1'b1;
            key_db   <= 1'b1;
            key_db_d <= 1'b1;
            db_cnt   <= '0;
        end else begin
            key_m    <= KEYn;
            key_s    <= key_m;
            key_db_d <= key_db;
            if (key_s == key_db) begin
                db_cnt <= '0;
            end else if (db_cnt == DB_W'(DB_CYCLES - 1)) begin
                // This is the DB_CYCLES-th consecutive differing cycle.
                key_db <= key_s;
                db_cnt <= '0;
            end else begin
                db_cnt <= db_cnt + 1'b1;
            end
        end
    end

    // Only the debounced falling edge is a press; release is silent.
    assign press = key_db_d && !key_db;

    // ---------------- FLAG synchronizer ----------------
    logic flag_m, flag_s;

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            flag_m <= 1'b0;
            flag_s <= 1'b0;
        end else begin
            flag_m <= FLAG;
            flag_s <= flag_m;
        end
    end

    // ---------------- FSM ----------------
    logic [DW_W-1:0] dwell;
    logic [DW_W-1:0] dwell_max;
    logic            dwell_ok;
    logic            time_up;
    logic [1:0]      state_n;
    logic            early_n;
    logic            timeout_n;

    // dwell >= 2 guarantees the datapath saw at least two slow ticks in this state.
    assign dwell_ok  = (dwell >= DW_W'(2));
    assign dwell_max = (state == S_TIMING) ? DW_W'(MAX_TICKS) : DW_W'(2);
    assign time_up   = tick && (dwell == DW_W'(MAX_TICKS - 1));

    always_comb begin
        state_n   = state;
        early_n   = Early;
        timeout_n = Timeout;
        case (state)
            S_IDLE: begin
                if (press && dwell_ok) begin
                    state_n   = S_DELAY;
                    early_n   = 1'b0;
                    timeout_n = 1'b0;
                end
            end
            S_DELAY: begin
                // A press beats a simultaneous flag: it is a false start.
                if (press) begin
                    state_n = S_IDLE;
                    early_n = 1'b1;
                end else if (flag_s && dwell_ok) begin
                    state_n = S_TIMING;
                end
            end
            S_TIMING: begin
                // A press on the timeout tick is still a valid reaction.
                if (press) begin
                    state_n = S_DISPLAY;
                end else if (time_up) begin
                    state_n   = S_DISPLAY;
                    timeout_n = 1'b1;
                end
            end
            default: begin
                if (press) begin
                    state_n = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state   <= S_IDLE;
            Early   <= 1'b0;
            Timeout <= 1'b0;
            dwell   <= '0;
        end else begin
            state   <= state_n;
            Early   <= early_n;
            Timeout <= timeout_n;
            if (state_n != state) begin
                dwell <= '0;
            end else if (tick && (dwell != dwell_max)) begin
                dwell <= dwell + 1'b1;
            end
        end
    end

endmodule
